// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: FSM encodings,
// prefix scancodes and the layout of a buffered key event.
package ps2_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DATA   = 2'd1;
   localparam logic [1:0] ST_PARITY = 2'd2;
   localparam logic [1:0] ST_STOP   = 2'd3;

   localparam logic [7:0] PS2_EXT = 8'hE0;
   localparam logic [7:0] PS2_REL = 8'hF0;

   localparam int EVT_W        = 10;
   localparam int EVT_CODE_LSB = 0;
   localparam int EVT_EXT_BIT  = 8;
   localparam int EVT_REL_BIT  = 9;

   typedef logic [EVT_W-1:0] ps2_event_t;

   function automatic ps2_event_t make_event(input logic rel, input logic ext,
                                             input logic [7:0] code);
      ps2_event_t evt;
      evt                          = '0;
      evt[EVT_CODE_LSB +: 8]       = code;
      evt[EVT_EXT_BIT]             = ext;
      evt[EVT_REL_BIT]             = rel;
      return evt;
   endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Small first-word-fall-through event buffer; a push into a full buffer is
// dropped and flagged unless a pop frees a slot in the same cycle.
module ps2_event_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop_req,
   output logic             valid,
   output logic [WIDTH-1:0] head,
   output logic             overflow
);

   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             full;
   logic             do_pop;
   logic             do_push;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      full     = (count_q == CNT_W'(DEPTH));
      do_pop   = (count_q != '0) && pop_req;
      do_push  = push && (!full || do_pop);
      ovf_d    = push && full && !do_pop;

      if (do_push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (do_push && !do_pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (do_pop && !do_push) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   assign valid    = (count_q != '0);
   assign head     = mem_q[rd_ptr_q];
   assign overflow = ovf_q;

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: conditions the two lines, deserializes 11-bit
// frames, folds E0/F0 prefixes into one event and queues events.
module ps2_kbd_rx
   import ps2_pkg::*;
#(
   parameter int DEGLITCH   = 4,
   parameter int TIMEOUT    = 20000,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk_sys,
   input  logic       reset_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       key_valid,
   input  logic       key_ready,
   output logic [7:0] key_code,
   output logic       key_ext,
   output logic       key_rel,
   output logic       err_frame,
   output logic       err_overflow,
   output logic       busy
);

   localparam int DG_W = (DEGLITCH > 1) ? $clog2(DEGLITCH + 1) : 1;
   localparam int TO_W = $clog2(TIMEOUT + 1);

   logic            clk_meta_q, clk_meta_d, clk_sync_q, clk_sync_d;
   logic            dat_meta_q, dat_meta_d, dat_sync_q, dat_sync_d;
   logic            clk_filt_q, clk_filt_d, dat_filt_q, dat_filt_d;
   logic [DG_W-1:0] clk_cnt_q, clk_cnt_d, dat_cnt_q, dat_cnt_d;
   logic            clk_prev_q, clk_prev_d;
   logic            fall;
   logic            bit_in;

   logic [1:0]      state_q, state_d;
   logic [2:0]      bit_cnt_q, bit_cnt_d;
   logic [7:0]      shift_q, shift_d;
   logic            parity_q, parity_d;
   logic            parity_ok_q, parity_ok_d;
   logic [TO_W-1:0] tmo_q, tmo_d;
   logic            tmo_hit;
   logic            ext_q, ext_d, rel_q, rel_d;
   logic            err_q, err_d;
   logic            push_q, push_d;
   ps2_event_t      evt_q, evt_d;
   ps2_event_t      head;

   // A filtered line only follows its synchronized input after DEGLITCH
   // consecutive samples of the new level.
   always_comb begin
      clk_meta_d = ps2_clk;
      clk_sync_d = clk_meta_q;
      dat_meta_d = ps2_data;
      dat_sync_d = dat_meta_q;
      clk_filt_d = clk_filt_q;
      dat_filt_d = dat_filt_q;
      clk_cnt_d  = '0;
      dat_cnt_d  = '0;
      if (clk_sync_q != clk_filt_q) begin
         if (clk_cnt_q == DG_W'(DEGLITCH - 1)) begin
            clk_filt_d = clk_sync_q;
         end else begin
            clk_cnt_d = clk_cnt_q + DG_W'(1);
         end
      end
      if (dat_sync_q != dat_filt_q) begin
         if (dat_cnt_q == DG_W'(DEGLITCH - 1)) begin
            dat_filt_d = dat_sync_q;
         end else begin
            dat_cnt_d = dat_cnt_q + DG_W'(1);
         end
      end
      clk_prev_d = clk_filt_q;
      fall       = clk_prev_q && !clk_filt_q;
      bit_in     = dat_filt_q;
   end

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      parity_d    = parity_q;
      parity_ok_d = parity_ok_q;
      ext_d       = ext_q;
      rel_d       = rel_q;
      err_d       = 1'b0;
      push_d      = 1'b0;
      evt_d       = evt_q;

      if (fall || (state_q == ST_IDLE)) begin
         tmo_d = '0;
      end else begin
         tmo_d = tmo_q + TO_W'(1);
      end
      tmo_hit = (state_q != ST_IDLE) && !fall && (tmo_q == TO_W'(TIMEOUT - 1));

      if (tmo_hit) begin
         state_d = ST_IDLE;
         tmo_d   = '0;
         err_d   = 1'b1;
         ext_d   = 1'b0;
         rel_d   = 1'b0;
      end else if (fall) begin
         case (state_q)
            ST_IDLE: begin
               if (!bit_in) begin
                  bit_cnt_d = 3'd0;
                  parity_d  = 1'b1;
                  state_d   = ST_DATA;
               end
            end
            ST_DATA: begin
               shift_d   = {bit_in, shift_q[7:1]};
               parity_d  = parity_q ^ bit_in;
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  state_d = ST_PARITY;
               end
            end
            ST_PARITY: begin
               parity_ok_d = (bit_in == parity_q);
               state_d     = ST_STOP;
            end
            default: begin
               state_d = ST_IDLE;
               if (bit_in && parity_ok_q) begin
                  if (shift_q == PS2_EXT) begin
                     ext_d = 1'b1;
                  end else if (shift_q == PS2_REL) begin
                     rel_d = 1'b1;
                  end else begin
                     push_d = 1'b1;
                     evt_d  = make_event(rel_q, ext_q, shift_q);
                     ext_d  = 1'b0;
                     rel_d  = 1'b0;
                  end
               end else begin
                  err_d = 1'b1;
                  ext_d = 1'b0;
                  rel_d = 1'b0;
               end
            end
         endcase
      end
   end

   // Line-conditioning stages reset to 1 so an idle bus never looks like an edge.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         clk_meta_q  <= 1'b1;
         clk_sync_q  <= 1'b1;
         dat_meta_q  <= 1'b1;
         dat_sync_q  <= 1'b1;
         clk_filt_q  <= 1'b1;
         dat_filt_q  <= 1'b1;
         clk_cnt_q   <= '0;
         dat_cnt_q   <= '0;
         clk_prev_q  <= 1'b1;
         state_q     <= ST_IDLE;
         bit_cnt_q   <= 3'd0;
         shift_q     <= 8'd0;
         parity_q    <= 1'b0;
         parity_ok_q <= 1'b0;
         tmo_q       <= '0;
         ext_q       <= 1'b0;
         rel_q       <= 1'b0;
         err_q       <= 1'b0;
         push_q      <= 1'b0;
         evt_q       <= '0;
      end else begin
         clk_meta_q  <= clk_meta_d;
         clk_sync_q  <= clk_sync_d;
         dat_meta_q  <= dat_meta_d;
         dat_sync_q  <= dat_sync_d;
         clk_filt_q  <= clk_filt_d;
         dat_filt_q  <= dat_filt_d;
         clk_cnt_q   <= clk_cnt_d;
         dat_cnt_q   <= dat_cnt_d;
         clk_prev_q  <= clk_prev_d;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         parity_q    <= parity_d;
         parity_ok_q <= parity_ok_d;
         tmo_q       <= tmo_d;
         ext_q       <= ext_d;
         rel_q       <= rel_d;
         err_q       <= err_d;
         push_q      <= push_d;
         evt_q       <= evt_d;
      end
   end

   ps2_event_fifo #(
      .WIDTH (EVT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk_sys),
      .rst_n     (reset_n),
      .push      (push_q),
      .push_data (evt_q),
      .pop_req   (key_ready),
      .valid     (key_valid),
      .head      (head),
      .overflow  (err_overflow)
   );

   assign key_code  = head[EVT_CODE_LSB +: 8];
   assign key_ext   = head[EVT_EXT_BIT];
   assign key_rel   = head[EVT_REL_BIT];
   assign err_frame = err_q;
   assign busy      = (state_q != ST_IDLE);

endmodule
